// File: rtl/bam_cfg_ctrl_pkg.sv
// Shared definitions for the BAM configuration controller: field widths
// and the controller state encoding.
package bam_cfg_ctrl_pkg;

   localparam int DC_W    = 8;
   localparam int PRESC_W = 3;
   localparam int PCT_W   = 7;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CAPTURE  = 3'd1;
   localparam logic [2:0] ST_DIVIDE   = 3'd2;
   localparam logic [2:0] ST_WAIT_BND = 3'd3;
   localparam logic [2:0] ST_COMMIT   = 3'd4;
   localparam logic [2:0] ST_REQ      = 3'd5;
   localparam logic [2:0] ST_ACK_LOW  = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE     = ST_IDLE,
      S_CAPTURE  = ST_CAPTURE,
      S_DIVIDE   = ST_DIVIDE,
      S_WAIT_BND = ST_WAIT_BND,
      S_COMMIT   = ST_COMMIT,
      S_REQ      = ST_REQ,
      S_ACK_LOW  = ST_ACK_LOW
   } state_t;

endpackage

// File: rtl/bam_cfg_ctrl_key_debounce.sv
// Active-low key conditioner: two-flop synchronizer, stable-low counter and
// a single press pulse per key press.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DB_CNT_W        = 19
)(
   input  logic CLOCK_50,
   input  logic arst,
   input  logic clr_i,
   input  logic key_n_i,
   output logic press_o
);

   // The counter parks one step past the firing value so the pulse
   // cannot repeat while the key stays held.
   localparam logic [DB_CNT_W-1:0] CNT_FIRE = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_CNT_W-1:0] CNT_SAT  = DB_CNT_W'(DEBOUNCE_CYCLES);

   logic                sync1_q;
   logic                key_s_q;
   logic [DB_CNT_W-1:0] cnt_q;
   logic [DB_CNT_W-1:0] cnt_d;

   // Next count: clear on release, count while held, stop at saturation.
   always_comb begin
      cnt_d = cnt_q;
      if (key_s_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Synchronizer and counter; released level (1) is the idle key state.
   always_ff @(posedge CLOCK_50 or negedge arst) begin
      if (!arst) begin
         sync1_q <= 1'b1;
         key_s_q <= 1'b1;
         cnt_q   <= '0;
      end else if (clr_i) begin
         sync1_q <= 1'b1;
         key_s_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_n_i;
         key_s_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = !clr_i && !key_s_q && (cnt_q == CNT_FIRE);

endmodule

// File: rtl/bam_cfg_ctrl.sv
// Sequences BAM configuration updates: latches switch settings on debounced
// key presses, derives the duty-cycle percentage, commits on a BAM period
// boundary and then handshakes a redraw with the VGA domain.
module bam_cfg_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DB_CNT_W        = 19,
   parameter int DC_W            = bam_cfg_ctrl_pkg::DC_W,
   parameter int PRESC_W         = bam_cfg_ctrl_pkg::PRESC_W
)(
   input  logic                              CLOCK_50,
   input  logic                              arst,
   input  logic                              i_on,
   input  logic                              i_key_presc_n,
   input  logic                              i_key_dc_n,
   input  logic [PRESC_W-1:0]                i_sw_presc,
   input  logic [DC_W-1:0]                   i_sw_dc,
   input  logic                              i_bam_enable,
   input  logic                              i_bam_period_end,
   input  logic                              i_redraw_ack,
   output logic [DC_W-1:0]                   o_duty_cycle,
   output logic [PRESC_W-1:0]                o_presc_mode,
   output logic [bam_cfg_ctrl_pkg::PCT_W-1:0] o_dc_percent,
   output logic                              o_redraw_req,
   output logic                              o_busy,
   output logic                              o_commit_led
);

   import bam_cfg_ctrl_pkg::*;

   localparam int DIV_CONST = 255;
   localparam int MUL_CONST = 100;
   // Dividend is duty*100; its top DC_W bits seed the partial remainder and
   // the low PCT_W bits are shifted in one per divide step.
   localparam int DVD_W     = DC_W + PCT_W;
   localparam logic [2:0] DIV_LAST = 3'(PCT_W - 1);

   state_t               state_q, state_d;
   logic                 pend_p_q, pend_p_d;
   logic                 pend_d_q, pend_d_d;
   logic [PRESC_W-1:0]   sh_presc_q, sh_presc_d;
   logic [DC_W-1:0]      sh_dc_q, sh_dc_d;
   logic [DC_W-1:0]      rem_q, rem_d;
   logic [PCT_W-1:0]     dvd_q, dvd_d;
   logic [PCT_W-1:0]     quo_q, quo_d;
   logic [2:0]           div_cnt_q, div_cnt_d;
   logic [DC_W-1:0]      duty_q, duty_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [PCT_W-1:0]     pct_q, pct_d;
   logic                 led_q, led_d;
   logic                 ack_s1_q, ack_s_q;
   logic                 press_p, press_d;
   logic [DVD_W-1:0]     dividend;
   logic [DC_W:0]        trial;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_CNT_W        (DB_CNT_W)
   ) u_db_presc (
      .CLOCK_50 (CLOCK_50),
      .arst     (arst),
      .clr_i    (!i_on),
      .key_n_i  (i_key_presc_n),
      .press_o  (press_p)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_CNT_W        (DB_CNT_W)
   ) u_db_dc (
      .CLOCK_50 (CLOCK_50),
      .arst     (arst),
      .clr_i    (!i_on),
      .key_n_i  (i_key_dc_n),
      .press_o  (press_d)
   );

   // Next state, shadow capture, restoring divider and commit values.
   always_comb begin
      state_d    = state_q;
      pend_p_d   = pend_p_q | press_p;
      pend_d_d   = pend_d_q | press_d;
      sh_presc_d = sh_presc_q;
      sh_dc_d    = sh_dc_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      quo_d      = quo_q;
      div_cnt_d  = div_cnt_q;
      duty_d     = duty_q;
      presc_d    = presc_q;
      pct_d      = pct_q;
      led_d      = led_q;
      dividend   = '0;
      trial      = {rem_q, dvd_q[PCT_W-1]};

      unique case (state_q)
         S_IDLE: begin
            if (pend_p_q || pend_d_q || press_p || press_d) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (pend_p_q) sh_presc_d = i_sw_presc;
            if (pend_d_q) sh_dc_d = i_sw_dc;
            // A press landing in this very cycle stays pending for next time.
            pend_p_d  = press_p;
            pend_d_d  = press_d;
            dividend  = DVD_W'(sh_dc_d) * DVD_W'(MUL_CONST);
            rem_d     = dividend[DVD_W-1 -: DC_W];
            dvd_d     = dividend[PCT_W-1:0];
            quo_d     = '0;
            div_cnt_d = '0;
            state_d   = S_DIVIDE;
         end
         S_DIVIDE: begin
            if (trial >= (DC_W+1)'(DIV_CONST)) begin
               rem_d = DC_W'(trial - (DC_W+1)'(DIV_CONST));
               quo_d = {quo_q[PCT_W-2:0], 1'b1};
            end else begin
               rem_d = trial[DC_W-1:0];
               quo_d = {quo_q[PCT_W-2:0], 1'b0};
            end
            dvd_d     = {dvd_q[PCT_W-2:0], 1'b0};
            div_cnt_d = div_cnt_q + 1'b1;
            if (div_cnt_q == DIV_LAST) begin
               state_d = S_WAIT_BND;
            end
         end
         S_WAIT_BND: begin
            // Outputs are loaded on the way into COMMIT so they are visible
            // the cycle right after the period boundary.
            if (!i_bam_enable || i_bam_period_end) begin
               duty_d  = sh_dc_q;
               presc_d = sh_presc_q;
               pct_d   = quo_q;
               led_d   = !led_q;
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (ack_s_q) state_d = S_ACK_LOW;
         end
         S_ACK_LOW: begin
            if (!ack_s_q) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register update; device-off clears everything just like reset.
   always_ff @(posedge CLOCK_50 or negedge arst) begin
      if (!arst) begin
         state_q    <= S_IDLE;
         pend_p_q   <= 1'b0;
         pend_d_q   <= 1'b0;
         sh_presc_q <= '0;
         sh_dc_q    <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         quo_q      <= '0;
         div_cnt_q  <= '0;
         duty_q     <= '0;
         presc_q    <= '0;
         pct_q      <= '0;
         led_q      <= 1'b0;
         ack_s1_q   <= 1'b0;
         ack_s_q    <= 1'b0;
      end else if (!i_on) begin
         state_q    <= S_IDLE;
         pend_p_q   <= 1'b0;
         pend_d_q   <= 1'b0;
         sh_presc_q <= '0;
         sh_dc_q    <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         quo_q      <= '0;
         div_cnt_q  <= '0;
         duty_q     <= '0;
         presc_q    <= '0;
         pct_q      <= '0;
         led_q      <= 1'b0;
         ack_s1_q   <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_p_q   <= pend_p_d;
         pend_d_q   <= pend_d_d;
         sh_presc_q <= sh_presc_d;
         sh_dc_q    <= sh_dc_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         quo_q      <= quo_d;
         div_cnt_q  <= div_cnt_d;
         duty_q     <= duty_d;
         presc_q    <= presc_d;
         pct_q      <= pct_d;
         led_q      <= led_d;
         ack_s1_q   <= i_redraw_ack;
         ack_s_q    <= ack_s1_q;
      end
   end

   assign o_duty_cycle = duty_q;
   assign o_presc_mode = presc_q;
   assign o_dc_percent = pct_q;
   assign o_commit_led = led_q;
   assign o_redraw_req = (state_q == S_REQ);
   assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bam_cfg_ctrl.sv
// Directed bench for bam_cfg_ctrl with a short debounce window.
module tb_bam_cfg_ctrl;

   localparam int SEL_REQ  = 0;
   localparam int SEL_BUSY = 1;
   localparam int SEL_LED  = 2;

   logic       CLOCK_50 = 1'b0;
   logic       arst = 1'b0;
   logic       i_on = 1'b1;
   logic       i_key_presc_n = 1'b1;
   logic       i_key_dc_n = 1'b1;
   logic [2:0] i_sw_presc = '0;
   logic [7:0] i_sw_dc = '0;
   logic       i_bam_enable = 1'b0;
   logic       i_bam_period_end = 1'b0;
   logic       i_redraw_ack = 1'b0;
   logic [7:0] o_duty_cycle;
   logic [2:0] o_presc_mode;
   logic [6:0] o_dc_percent;
   logic       o_redraw_req;
   logic       o_busy;
   logic       o_commit_led;

   int checks = 0;
   int errors = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   bam_cfg_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .DB_CNT_W        (19),
      .DC_W            (8),
      .PRESC_W         (3)
   ) dut (
      .CLOCK_50         (CLOCK_50),
      .arst             (arst),
      .i_on             (i_on),
      .i_key_presc_n    (i_key_presc_n),
      .i_key_dc_n       (i_key_dc_n),
      .i_sw_presc       (i_sw_presc),
      .i_sw_dc          (i_sw_dc),
      .i_bam_enable     (i_bam_enable),
      .i_bam_period_end (i_bam_period_end),
      .i_redraw_ack     (i_redraw_ack),
      .o_duty_cycle     (o_duty_cycle),
      .o_presc_mode     (o_presc_mode),
      .o_dc_percent     (o_dc_percent),
      .o_redraw_req     (o_redraw_req),
      .o_busy           (o_busy),
      .o_commit_led     (o_commit_led)
   );

   task automatic wait_edges(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   function automatic logic sig(input int sel);
      if (sel == SEL_REQ) return o_redraw_req;
      if (sel == SEL_BUSY) return o_busy;
      return o_commit_led;
   endfunction

   // Bounded wait for a DUT output level; an expired bound counts as a failure.
   task automatic wait_for(input int sel, input logic val, input string name);
      int n;
      n = 0;
      checks++;
      while (n < 200 && sig(sel) !== val) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (sig(sel) !== val) begin
         errors++;
         $display("FAIL %s timeout: signal %0d is %b, required %b", name, sel, sig(sel), val);
      end
   endtask

   task automatic handshake(input string name);
      wait_for(SEL_REQ, 1'b1, {name, "_req_hi"});
      i_redraw_ack = 1'b1;
      wait_for(SEL_REQ, 1'b0, {name, "_req_lo"});
      i_redraw_ack = 1'b0;
      wait_for(SEL_BUSY, 1'b0, {name, "_idle"});
   endtask

   task automatic test_reset();
      arst = 1'b0;
      wait_edges(3);
      checks++;
      if ({o_duty_cycle, o_presc_mode, o_dc_percent, o_redraw_req, o_busy, o_commit_led} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got dc=%0d presc=%0d pct=%0d req=%b busy=%b led=%b, required all 0",
                  o_duty_cycle, o_presc_mode, o_dc_percent, o_redraw_req, o_busy, o_commit_led);
      end
      arst = 1'b1;
      wait_edges(2);
   endtask

   task automatic test_dc_only();
      i_sw_dc = 8'd255;
      i_bam_enable = 1'b0;
      i_key_dc_n = 1'b0;
      wait_edges(5);
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL dc_busy_pre: got %b required 0", o_busy); end
      wait_edges(1);
      checks++;
      if (o_busy !== 1'b1) begin errors++; $display("FAIL dc_busy_post: got %b required 1", o_busy); end
      wait_edges(8);
      checks++;
      if (o_duty_cycle !== 8'd0) begin errors++; $display("FAIL dc_early: got %0d required 0", o_duty_cycle); end
      wait_edges(1);
      checks++;
      if (o_duty_cycle !== 8'd255) begin errors++; $display("FAIL dc_value: got %0d required 255", o_duty_cycle); end
      checks++;
      if (o_dc_percent !== 7'd100) begin errors++; $display("FAIL dc_percent: got %0d required 100", o_dc_percent); end
      checks++;
      if (o_commit_led !== 1'b1) begin errors++; $display("FAIL dc_led: got %b required 1", o_commit_led); end
      checks++;
      if (o_presc_mode !== 3'd0) begin errors++; $display("FAIL dc_presc_kept: got %0d required 0", o_presc_mode); end
      wait_edges(1);
      checks++;
      if (o_redraw_req !== 1'b1) begin errors++; $display("FAIL dc_req: got %b required 1", o_redraw_req); end
      i_key_dc_n = 1'b1;
      handshake("dc_only");
   endtask

   task automatic test_percent();
      logic [7:0] dcs  [4] = '{8'd128, 8'd64, 8'd0, 8'd1};
      logic [6:0] pcts [4] = '{7'd50, 7'd25, 7'd0, 7'd0};
      logic       prev;
      for (int i = 0; i < 4; i++) begin
         prev = o_commit_led;
         i_sw_dc = dcs[i];
         i_key_dc_n = 1'b0;
         wait_for(SEL_LED, !prev, "pct_commit");
         checks++;
         if (o_duty_cycle !== dcs[i]) begin
            errors++; $display("FAIL pct_dc[%0d]: got %0d required %0d", i, o_duty_cycle, dcs[i]);
         end
         checks++;
         if (o_dc_percent !== pcts[i]) begin
            errors++; $display("FAIL pct_val[%0d]: got %0d required %0d", i, o_dc_percent, pcts[i]);
         end
         i_key_dc_n = 1'b1;
         handshake("pct");
      end
   endtask

   task automatic test_bam_boundary();
      logic prev;
      prev = o_commit_led;
      i_bam_enable = 1'b1;
      i_sw_presc = 3'd5;
      i_key_presc_n = 1'b0;
      wait_edges(30);
      checks++;
      if (o_presc_mode !== 3'd0 || o_busy !== 1'b1) begin
         errors++; $display("FAIL bnd_wait: got presc=%0d busy=%b required presc=0 busy=1", o_presc_mode, o_busy);
      end
      i_key_presc_n = 1'b1;
      wait_edges(10);
      i_bam_period_end = 1'b1;
      checks++;
      if (o_presc_mode !== 3'd0) begin errors++; $display("FAIL bnd_pulse_cycle: got %0d required 0", o_presc_mode); end
      wait_edges(1);
      i_bam_period_end = 1'b0;
      checks++;
      if (o_presc_mode !== 3'd5) begin errors++; $display("FAIL bnd_presc: got %0d required 5", o_presc_mode); end
      checks++;
      if (o_duty_cycle !== 8'd1 || o_dc_percent !== 7'd0) begin
         errors++; $display("FAIL bnd_dc_kept: got dc=%0d pct=%0d required dc=1 pct=0", o_duty_cycle, o_dc_percent);
      end
      checks++;
      if (o_commit_led !== !prev) begin errors++; $display("FAIL bnd_led: got %b required %b", o_commit_led, !prev); end
      handshake("bnd");
      i_bam_enable = 1'b0;
   endtask

   task automatic test_both_keys();
      logic prev;
      prev = o_commit_led;
      i_sw_presc = 3'd3;
      i_sw_dc = 8'd200;
      i_key_presc_n = 1'b0;
      i_key_dc_n = 1'b0;
      wait_for(SEL_LED, !prev, "both_commit");
      checks++;
      if (o_presc_mode !== 3'd3 || o_duty_cycle !== 8'd200 || o_dc_percent !== 7'd78) begin
         errors++; $display("FAIL both_vals: got presc=%0d dc=%0d pct=%0d required 3 200 78",
                            o_presc_mode, o_duty_cycle, o_dc_percent);
      end
      i_key_presc_n = 1'b1;
      i_key_dc_n = 1'b1;
      handshake("both");
      wait_edges(30);
      checks++;
      if (o_commit_led !== !prev || o_busy !== 1'b0) begin
         errors++; $display("FAIL both_single: got led=%b busy=%b required led=%b busy=0", o_commit_led, o_busy, !prev);
      end
   endtask

   task automatic test_back_to_back();
      logic prev;
      prev = o_commit_led;
      i_sw_dc = 8'd77;
      i_key_dc_n = 1'b0;
      wait_for(SEL_LED, !prev, "b2b_first");
      checks++;
      if (o_duty_cycle !== 8'd77 || o_dc_percent !== 7'd30) begin
         errors++; $display("FAIL b2b_first_vals: got dc=%0d pct=%0d required 77 30", o_duty_cycle, o_dc_percent);
      end
      i_key_dc_n = 1'b1;
      wait_for(SEL_REQ, 1'b1, "b2b_req");
      for (int k = 0; k < 3; k++) begin
         i_key_dc_n = 1'b0;
         wait_edges(8);
         i_key_dc_n = 1'b1;
         wait_edges(4);
      end
      checks++;
      if (o_redraw_req !== 1'b1 || o_duty_cycle !== 8'd77) begin
         errors++; $display("FAIL b2b_hold: got req=%b dc=%0d required req=1 dc=77", o_redraw_req, o_duty_cycle);
      end
      i_sw_dc = 8'd10;
      prev = o_commit_led;
      i_redraw_ack = 1'b1;
      wait_for(SEL_REQ, 1'b0, "b2b_ack");
      i_redraw_ack = 1'b0;
      wait_for(SEL_LED, !prev, "b2b_second");
      checks++;
      if (o_duty_cycle !== 8'd10 || o_dc_percent !== 7'd3) begin
         errors++; $display("FAIL b2b_second_vals: got dc=%0d pct=%0d required 10 3", o_duty_cycle, o_dc_percent);
      end
      handshake("b2b");
      wait_edges(30);
      checks++;
      if (o_commit_led !== !prev || o_busy !== 1'b0) begin
         errors++; $display("FAIL b2b_once: got led=%b busy=%b required led=%b busy=0", o_commit_led, o_busy, !prev);
      end
   endtask

   task automatic test_bounce();
      logic prev;
      logic seen;
      prev = o_commit_led;
      seen = 1'b0;
      i_redraw_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_key_dc_n = 1'b0;
         for (int j = 0; j < 3; j++) begin @(negedge CLOCK_50); seen |= o_busy; end
         i_key_dc_n = 1'b1;
         for (int j = 0; j < 3; j++) begin @(negedge CLOCK_50); seen |= o_busy; end
      end
      for (int j = 0; j < 12; j++) begin @(negedge CLOCK_50); seen |= o_busy; end
      i_redraw_ack = 1'b0;
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL bounce_busy: got busy seen=%b required 0", seen); end
      checks++;
      if (o_commit_led !== prev) begin errors++; $display("FAIL bounce_led: got %b required %b", o_commit_led, prev); end
      wait_edges(4);
   endtask

   task automatic test_on_low();
      i_bam_enable = 1'b1;
      i_sw_dc = 8'd50;
      i_key_dc_n = 1'b0;
      wait_edges(20);
      i_key_dc_n = 1'b1;
      checks++;
      if (o_busy !== 1'b1) begin errors++; $display("FAIL on_busy: got %b required 1", o_busy); end
      i_on = 1'b0;
      wait_edges(1);
      checks++;
      if ({o_duty_cycle, o_presc_mode, o_dc_percent, o_redraw_req, o_busy, o_commit_led} !== 21'd0) begin
         errors++; $display("FAIL on_clear: got dc=%0d presc=%0d pct=%0d req=%b busy=%b led=%b, required all 0",
                            o_duty_cycle, o_presc_mode, o_dc_percent, o_redraw_req, o_busy, o_commit_led);
      end
      i_on = 1'b1;
      wait_edges(20);
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL on_no_pending: got busy=%b required 0", o_busy); end
      i_bam_enable = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic prev;
      prev = o_commit_led;
      i_sw_presc = 3'd6;
      i_sw_dc = 8'd200;
      i_key_dc_n = 1'b0;
      i_key_presc_n = 1'b0;
      wait_for(SEL_LED, !prev, "rst_setup");
      i_key_dc_n = 1'b1;
      i_key_presc_n = 1'b1;
      handshake("rst_setup");
      i_bam_enable = 1'b1;
      i_sw_dc = 8'd9;
      i_key_dc_n = 1'b0;
      wait_edges(20);
      i_key_dc_n = 1'b1;
      checks++;
      if (o_busy !== 1'b1 || o_duty_cycle !== 8'd200) begin
         errors++; $display("FAIL rst_pre: got busy=%b dc=%0d required busy=1 dc=200", o_busy, o_duty_cycle);
      end
      arst = 1'b0;
      #1;
      checks++;
      if ({o_duty_cycle, o_presc_mode, o_dc_percent, o_redraw_req, o_busy, o_commit_led} !== 21'd0) begin
         errors++; $display("FAIL rst_async: got dc=%0d presc=%0d pct=%0d req=%b busy=%b led=%b, required all 0",
                            o_duty_cycle, o_presc_mode, o_dc_percent, o_redraw_req, o_busy, o_commit_led);
      end
      wait_edges(2);
      arst = 1'b1;
      wait_edges(20);
      checks++;
      if (o_busy !== 1'b0 || o_duty_cycle !== 8'd0) begin
         errors++; $display("FAIL rst_after: got busy=%b dc=%0d required busy=0 dc=0", o_busy, o_duty_cycle);
      end
      i_bam_enable = 1'b0;
   endtask

   initial begin
      @(negedge CLOCK_50);
      test_reset();
      test_dc_only();
      test_percent();
      test_bam_boundary();
      test_both_keys();
      test_back_to_back();
      test_bounce();
      test_on_low();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bam_cfg_ctrl.md
Name: bam_cfg_ctrl

Overview:
- Controller that sequences configuration updates of the BAM channel and the matching VGA redraw.
- Debounces the two active-low latch keys and captures the switch settings into shadow registers.
- Computes the duty-cycle percentage with a sequential divider and commits new settings only on a BAM period boundary.
- Then runs a 4-phase req/ack handshake to the 25 MHz VGA drawing logic. Sits between the board switches/keys and the BAM and VGA RGB instances.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-low cycles required to accept a key press (10 ms at 50 MHz).
- DB_CNT_W, 19, width of the debounce counters.
- DC_W, 8, duty-cycle width.
- PRESC_W, 3, prescaler-mode width.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- arst  in  1  asynchronous active-low reset.
- i_on  in  1  device enable (SW[0]).
- i_key_presc_n  in  1  raw prescaler latch key, active low.
- i_key_dc_n  in  1  raw duty-cycle latch key, active low.
- i_sw_presc  in  PRESC_W  prescaler switch value.
- i_sw_dc  in  DC_W  duty-cycle switch value.
- i_bam_enable  in  1  BAM channel alive.
- i_bam_period_end  in  1  one-cycle pulse at the last tick of a BAM period.
- i_redraw_ack  in  1  VGA-domain acknowledge, asynchronous to CLOCK_50.
- o_duty_cycle  out  DC_W  committed duty cycle to BAM.
- o_presc_mode  out  PRESC_W  committed prescaler mode to BAM.
- o_dc_percent  out  7  floor(o_duty_cycle*100/255) to VGA.
- o_redraw_req  out  1  redraw request, level.
- o_busy  out  1  high whenever state is not IDLE.
- o_commit_led  out  1  toggles on every commit.

Behaviour:
- Reset (arst low, async): all outputs, shadow registers, pending flags and debounce counters go to 0; state goes to IDLE.
- i_on low (synchronous, highest priority after reset): same clearing as reset, every cycle.
- Raw keys: 2-flop synchronized.
- Debounce per key: the counter increments while the synchronized key is low and clears when it is high.
  - At count == DEBOUNCE_CYCLES-1, a one-cycle press pulse fires and the counter saturates until release.
  - Exactly one pulse per press.
- Pending flags pend_p and pend_d are set by press pulses and cleared on CAPTURE. Presses while busy coalesce into one pending update.
- FSM states: IDLE, CAPTURE, DIVIDE, WAIT_BND, COMMIT, REQ, ACK_LOW.
- IDLE -> CAPTURE when pend_p or pend_d is set.
- CAPTURE (1 cycle):
  - If pend_p: sh_presc <= i_sw_presc. If pend_d: sh_dc <= i_sw_dc. Otherwise the shadow keeps the committed value.
  - Both keys pending in the same cycle are handled in one transaction.
  - Loads dividend = sh_dc*100 (15 bits) into the divider, then goes to DIVIDE.
- DIVIDE: restoring division by 255, one quotient bit per cycle, exactly 7 cycles, yields a 7-bit quotient in range 0..100. Then -> WAIT_BND.
- WAIT_BND:
  - -> COMMIT on the cycle i_bam_period_end is high.
  - -> COMMIT immediately if i_bam_enable is low, so no deadlock when the channel is off.
- COMMIT (1 cycle): o_duty_cycle, o_presc_mode and o_dc_percent update together; o_commit_led toggles. Then -> REQ.
- REQ: o_redraw_req = 1 until the synchronized ack (2-flop) reads 1, then -> ACK_LOW with req = 0.
- ACK_LOW: wait until the synchronized ack reads 0, then -> IDLE.
- Latency: press pulse to outputs updated is 1 (IDLE) + 1 (CAPTURE) + 7 (DIVIDE) + 1 cycles minimum, with BAM disabled.
- Outputs never change outside COMMIT, except on reset or i_on low.
- A press arriving during any non-IDLE state is kept pending. Switch values are sampled at CAPTURE, not at the press.
- Ack high while in IDLE is ignored.

Decomposition:
- Shared package holds: the FSM state encoding (3-bit localparams), DC_W, PRESC_W, and PCT_W = 7.
- DIV_CONST = 255 and MUL_CONST = 100 stay local to bam_cfg_ctrl.
- One sub-module, key_debounce (synchronizer + counter + press pulse), instantiated twice.

Test Plan:
- Press dc key only; sw_dc = 255, BAM off, DEBOUNCE_CYCLES = 4 -> o_duty_cycle = 255 and o_dc_percent = 100 after 10 cycles from the press pulse; o_commit_led toggles; o_redraw_req rises.
- sw_dc values 128 / 64 / 1 / 0 -> o_dc_percent 50 / 25 / 0 / 0.
- BAM enabled, period_end every 40 cycles, press presc key with sw_presc = 5 -> o_presc_mode stays 0 until the cycle after the period_end pulse, then reads 5.
- Both keys pressed in the same cycle with sw_presc = 3, sw_dc = 200 -> single commit (o_commit_led toggles once) with presc 3, dc 200, percent 78.
- Three dc presses during REQ, sw_dc changed to 10 before return to IDLE -> exactly one further transaction, committing 10 (percent 3).
- Key bounce shorter than DEBOUNCE_CYCLES -> no press pulse. Reset or i_on low mid-WAIT_BND -> outputs 0, state IDLE, req 0.
